// File: rtl/pwm_capture.sv
// PWM capture: times the high phase and full period of an asynchronous PWM input
// and converts them to a 10-bit duty value with a sequential restoring divider.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [9:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t           state_r;
    logic [2:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] h_r;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] div_p_r;
    logic [CNT_W-1:0] div_h_r;
    logic [8:0]       quo_r;
    logic [3:0]       div_cnt_r;

    logic [9:0]       duty_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic             valid_r;
    logic             stuck_r;
    logic             overrun_r;

    logic             rise_s;
    logic             fall_s;
    logic             cnt_max_s;
    logic             busy_s;
    logic             div_done_s;
    logic             launch_s;
    logic [CNT_W:0]   rem_sh_s;
    logic [CNT_W:0]   rem_dif_s;
    logic [CNT_W-1:0] rem_nxt_s;
    logic [9:0]       quo_nxt_s;

    assign rise_s     = sync_r[1] & ~sync_r[2];
    assign fall_s     = ~sync_r[1] & sync_r[2];
    assign cnt_max_s  = (cnt_r == MAX);
    assign busy_s     = (div_cnt_r != 4'd0);
    assign div_done_s = (div_cnt_r == 4'd1);
    assign launch_s   = (state_r == ST_LOW) && rise_s && !cnt_max_s && !busy_s;

    assign duty      = duty_r;
    assign period    = period_r;
    assign high_time = high_r;
    assign valid     = valid_r;
    assign stuck     = stuck_r;
    assign overrun   = overrun_r;

    // Three-flop synchroniser; the last two stages feed edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], pwm_in};
        end
    end

    // Cycle counter since the last rising edge, saturating at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= ZERO;
        end else if (rise_s) begin
            cnt_r <= ONE;
        end else if (!cnt_max_s) begin
            cnt_r <= cnt_r + ONE;
        end
    end

    // One restoring-division step; the borrow bit of the trial subtraction decides the quotient bit.
    always_comb begin
        rem_sh_s  = {rem_r, 1'b0};
        rem_dif_s = rem_sh_s - {1'b0, div_p_r};
        if (!rem_dif_s[CNT_W]) begin
            rem_nxt_s = rem_dif_s[CNT_W-1:0];
            quo_nxt_s = {quo_r, 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[CNT_W-1:0];
            quo_nxt_s = {quo_r, 1'b0};
        end
    end

    // Divider sequencing: ten iterations after launch, one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r     <= ZERO;
            div_p_r   <= ZERO;
            div_h_r   <= ZERO;
            quo_r     <= 9'd0;
            div_cnt_r <= 4'd0;
        end else if (launch_s) begin
            rem_r     <= h_r;
            div_p_r   <= cnt_r;
            div_h_r   <= h_r;
            quo_r     <= 9'd0;
            div_cnt_r <= 4'd10;
        end else if (busy_s) begin
            rem_r     <= rem_nxt_s;
            quo_r     <= quo_nxt_s[8:0];
            div_cnt_r <= div_cnt_r - 4'd1;
        end
    end

    // Measurement FSM with registered result, status and pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            h_r       <= ZERO;
            duty_r    <= 10'd0;
            period_r  <= ZERO;
            high_r    <= ZERO;
            valid_r   <= 1'b0;
            stuck_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            if (div_done_s) begin
                duty_r   <= quo_nxt_s;
                period_r <= div_p_r;
                high_r   <= div_h_r;
                valid_r  <= 1'b1;
                stuck_r  <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_r <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt_max_s) begin
                        state_r  <= ST_IDLE;
                        duty_r   <= 10'd1023;
                        period_r <= MAX;
                        high_r   <= MAX;
                        valid_r  <= 1'b1;
                        stuck_r  <= 1'b1;
                    end else if (fall_s) begin
                        h_r     <= cnt_r;
                        state_r <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (cnt_max_s) begin
                        state_r  <= ST_IDLE;
                        duty_r   <= 10'd0;
                        period_r <= MAX;
                        high_r   <= ZERO;
                        valid_r  <= 1'b1;
                        stuck_r  <= 1'b1;
                    end else if (rise_s) begin
                        state_r <= ST_HIGH;
                        if (busy_s) begin
                            overrun_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two instances (CNT_W 16 and 8) checked every cycle against an
// edge-timestamp model, plus literal expectations for the directed scenarios.
module tb_pwm_capture;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pin16 = 1'b0;
    logic pin8  = 1'b0;

    logic [9:0]  duty16, duty8;
    logic [15:0] period16, high16;
    logic [7:0]  period8, high8;
    logic        valid16, stuck16, ovr16, valid8, stuck8, ovr8;

    pwm_capture #(.CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pin16), .duty(duty16), .period(period16),
        .high_time(high16), .valid(valid16), .stuck(stuck16), .overrun(ovr16)
    );

    pwm_capture #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .pwm_in(pin8), .duty(duty8), .period(period8),
        .high_time(high8), .valid(valid8), .stuck(stuck8), .overrun(ovr8)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Model state, indexed 0 = 16-bit instance, 1 = 8-bit instance.
    longint ecount = 0;
    longint mx[2] = '{65535, 255};
    int     mode[2];            // 0 unarmed, 1 timing high phase, 2 timing low phase
    longint rise_e[2], done_e[2], h_m[2];
    logic   pend[2];
    longint pd_duty[2], pd_p[2], pd_h[2];
    logic [2:0] ph[2];
    longint e_duty[2], e_period[2], e_high[2];
    logic   e_valid[2], e_stuck[2], e_ovr[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; rise_e[i] = 0; done_e[i] = 0; h_m[i] = 0; pend[i] = 1'b0;
            pd_duty[i] = 0; pd_p[i] = 0; pd_h[i] = 0; ph[i] = 3'b000;
            e_duty[i] = 0; e_period[i] = 0; e_high[i] = 0;
            e_valid[i] = 1'b0; e_stuck[i] = 1'b0; e_ovr[i] = 1'b0;
        end
    endtask

    // Edges are acted on three clock edges after the pin level is first sampled.
    task automatic model_step(input int i, input logic pin);
        logic rs, fl, busy;
        longint p;
        rs = ph[i][1] & ~ph[i][2];
        fl = ~ph[i][1] & ph[i][2];
        ph[i] = {ph[i][1:0], pin};
        busy = pend[i];
        e_valid[i] = 1'b0;
        e_ovr[i]   = 1'b0;
        if (pend[i] && ecount == done_e[i]) begin
            e_duty[i] = pd_duty[i]; e_period[i] = pd_p[i]; e_high[i] = pd_h[i];
            e_valid[i] = 1'b1; e_stuck[i] = 1'b0; pend[i] = 1'b0;
        end
        if (mode[i] != 0 && ecount - rise_e[i] >= mx[i]) begin
            e_valid[i]  = 1'b1;
            e_stuck[i]  = 1'b1;
            e_period[i] = mx[i];
            e_high[i]   = (mode[i] == 1) ? mx[i] : 0;
            e_duty[i]   = (mode[i] == 1) ? 1023 : 0;
            mode[i]     = 0;
        end else if (mode[i] == 0) begin
            if (rs) begin
                mode[i] = 1; rise_e[i] = ecount;
            end
        end else if (mode[i] == 1) begin
            if (fl) begin
                h_m[i] = ecount - rise_e[i]; mode[i] = 2;
            end
        end else if (rs) begin
            p = ecount - rise_e[i];
            if (busy) begin
                e_ovr[i] = 1'b1;
            end else begin
                pend[i] = 1'b1; done_e[i] = ecount + 10;
                pd_duty[i] = (h_m[i] * 1024) / p; pd_p[i] = p; pd_h[i] = h_m[i];
            end
            rise_e[i] = ecount; mode[i] = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                ecount++;
                model_step(0, pin16);
                model_step(1, pin8);
            end
        end
    end

    // Captured DUT results for the literal checks.
    logic   cmp_en = 1'b0;
    int     vcnt[2] = '{0, 0};
    int     ocnt[2] = '{0, 0};
    longint l_duty[2], l_period[2], l_high[2];
    logic   lat_arm = 1'b0;
    longint lat = -1;
    longint pin_rise_edge = 0;
    logic   p4_on = 1'b0;
    int     p4_acc = 0;
    int     p4_bad = 0;

    task automatic cmp_inst(input int i, input string tag, input longint d, input longint p,
                            input longint h, input logic v, input logic s, input logic o);
        check({tag, ".duty"}, d, e_duty[i]);
        check({tag, ".period"}, p, e_period[i]);
        check({tag, ".high_time"}, h, e_high[i]);
        check({tag, ".valid"}, longint'(v), longint'(e_valid[i]));
        check({tag, ".stuck"}, longint'(s), longint'(e_stuck[i]));
        check({tag, ".overrun"}, longint'(o), longint'(e_ovr[i]));
        if (v) begin
            vcnt[i]++;
            l_duty[i] = d; l_period[i] = p; l_high[i] = h;
            if (i == 0 && lat_arm) begin
                lat = ecount - pin_rise_edge;
                lat_arm = 1'b0;
            end
            if (i == 0 && p4_on) begin
                p4_acc++;
                if (d != 512) p4_bad++;
            end
        end
        if (o) ocnt[i]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                cmp_inst(0, "d16", longint'(duty16), longint'(period16), longint'(high16),
                         valid16, stuck16, ovr16);
                cmp_inst(1, "d8", longint'(duty8), longint'(period8), longint'(high8),
                         valid8, stuck8, ovr8);
            end
        end
    end

    task automatic set_pin(input int which, input logic v);
        if (which == 0) begin
            if (v && !pin16) pin_rise_edge = ecount;
            pin16 = v;
        end else begin
            pin8 = v;
        end
    endtask

    task automatic wave(input int which, input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < per; c++) begin
                @(posedge clk);
                #1;
                set_pin(which, c < hi);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    int v0;
    int o0;

    initial begin
        idle(5);
        #1;
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset.duty", longint'(duty16), 0);
        check("reset.period", longint'(period16), 0);
        check("reset.valid", longint'(valid16), 0);
        check("reset.stuck", longint'(stuck8), 0);

        // 100/25: pin rise to valid is 2 sync cycles + 11 divider cycles
        v0 = vcnt[0];
        lat_arm = 1'b1;
        wave(0, 100, 25, 5);
        idle(20);
        check("p100h25.latency", lat, 13);
        check("p100h25.duty", l_duty[0], 256);
        check("p100h25.period", l_period[0], 100);
        check("p100h25.high", l_high[0], 25);
        check("p100h25.count", longint'(vcnt[0] - v0), 4);
        check("p100h25.overruns", longint'(ocnt[0]), 0);

        wave(0, 100, 99, 4);
        idle(20);
        check("p100h99.duty", l_duty[0], 1013);
        check("p100h99.high", l_high[0], 99);

        wave(0, 1000, 1, 3);
        idle(20);
        check("p1000h1.duty", l_duty[0], 1);
        check("p1000h1.period", l_period[0], 1000);

        // Fast input: most rises land in the divider's busy window
        wave(0, 4, 2, 5);
        o0 = ocnt[0];
        p4_on = 1'b1;
        wave(0, 4, 2, 40);
        p4_on = 1'b0;
        idle(20);
        check("p4.bad_duty", longint'(p4_bad), 0);
        check("p4.accepted", longint'(p4_acc >= 10), 1);
        check("p4.overrun_seen", longint'(ocnt[0] > o0), 1);
        check("p4.duty", l_duty[0], 512);

        // Reset in the middle of a divide
        wave(0, 100, 25, 1);
        @(posedge clk);
        #1;
        set_pin(0, 1'b1);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.duty", longint'(duty16), 0);
        check("rst.period", longint'(period16), 0);
        check("rst.high", longint'(high16), 0);
        check("rst.valid", longint'(valid16), 0);
        check("rst.stuck", longint'(stuck16), 0);
        check("rst.overrun", longint'(ovr16), 0);
        pin16 = 1'b0;
        v0 = vcnt[0];
        idle(3);
        #1;
        rst_n = 1'b1;
        idle(30);
        check("rst.no_valid", longint'(vcnt[0] - v0), 0);
        wave(0, 100, 25, 3);
        idle(20);
        check("rst.resume_count", longint'(vcnt[0] - v0), 2);
        check("rst.resume_duty", l_duty[0], 256);
        check("rst.resume_period", l_period[0], 100);
        check("rst.resume_high", l_high[0], 25);

        // 8-bit instance: stuck low, recovery, stuck high
        v0 = vcnt[1];
        wave(1, 20, 10, 1);
        idle(300);
        check("stuck_lo.stuck", longint'(stuck8), 1);
        check("stuck_lo.duty", longint'(duty8), 0);
        check("stuck_lo.period", longint'(period8), 255);
        check("stuck_lo.high", longint'(high8), 0);
        check("stuck_lo.count", longint'(vcnt[1] - v0), 1);

        v0 = vcnt[1];
        wave(1, 40, 10, 3);
        idle(20);
        check("recover.count", longint'(vcnt[1] - v0), 2);
        check("recover.duty", longint'(duty8), 256);
        check("recover.period", longint'(period8), 40);
        check("recover.stuck", longint'(stuck8), 0);

        @(posedge clk);
        #1;
        set_pin(1, 1'b1);
        idle(300);
        check("stuck_hi.stuck", longint'(stuck8), 1);
        check("stuck_hi.duty", longint'(duty8), 1023);
        check("stuck_hi.period", longint'(period8), 255);
        check("stuck_hi.high", longint'(high8), 255);
        set_pin(1, 1'b0);
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the duty cycle and period of an externally driven PWM signal, such as a servo or motor-drive feedback line or a loop-back of the LED PWM output. It is the receive-side counterpart of the team's free-running PWM generators. It synchronises the asynchronous input and times the high phase and the full period in `clk` cycles. A 10-bit duty value on the same 0..1023 scale as the generators' `pwm_count` is produced by a sequential divider. The block sits between an input pin and the control logic that compares commanded and measured duty.

## Interface
- `CNT_W`, default 16: width of the period and high-time counters; legal range 8..32; saturation value MAX = 2^CNT_W − 1.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `pwm_in`, input, 1: asynchronous PWM input.
- `duty`, output, 10: floor(high_time × 1024 / period).
- `period`, output, CNT_W: last accepted period in clk cycles.
- `high_time`, output, CNT_W: last accepted high time in clk cycles.
- `valid`, output, 1: one-cycle pulse when `duty`, `period` and `high_time` update together.
- `stuck`, output, 1: level; input has had no edge for MAX cycles.
- `overrun`, output, 1: one-cycle pulse when a completed measurement is discarded.

## Operation
- Reset values: all outputs 0; FSM in IDLE; divider idle; synchroniser flops 0.
- Synchroniser: `pwm_in` → s1 → s2 → s3. `rise` = s2 & ~s3; `fall` = ~s2 & s3.
- Counter `cnt` (CNT_W bits):
  - Loads 1 on every `rise`.
  - Otherwise increments by 1, saturating at MAX.
- FSM states:
  - IDLE: on `rise`, go to HIGH. This first edge only arms the block; no output is produced.
  - HIGH: on `fall`, capture h = `cnt` and go to LOW. If `cnt` == MAX, take the timeout path with level 1.
  - LOW: on `rise`, capture p = `cnt` and go to HIGH. Reload `cnt` to 1 at the same time. If the divider is idle, launch it with (h, p). If the divider is busy, discard (h, p) and pulse `overrun`. If `cnt` == MAX, take the timeout path with level 0.
- Timeout path:
  - Go to IDLE and set `stuck` = 1.
  - Level 1 (stuck high): `duty` = 1023, `period` = MAX, `high_time` = MAX.
  - Level 0 (stuck low): `duty` = 0, `period` = MAX, `high_time` = 0.
  - Pulse `valid`.
  - The divider is always idle at this point, because MAX > 10.
- `stuck` clears on the next `valid` produced by the divider.
- Divider: restoring, 10 iterations, one per cycle, remainder width CNT_W+1.
  - Start with rem = h.
  - Each iteration: rem = rem << 1. If rem ≥ p, subtract p and shift in quotient bit 1; otherwise shift in 0.
  - h < p always holds, so the quotient fits in 10 bits without saturation.
- Result update: `duty` ← quotient, `period` ← p, `high_time` ← h, all three together with `valid`. Outputs hold between updates.

## Timing
- Latency from pin to detection: a `pwm_in` edge that is stable before clk edge k is seen as `rise`/`fall` in cycle k+2.
- Counting from a `rise` in cycle t:
  - A `fall` in cycle t+H gives h = H.
  - The next `rise` in cycle t+P gives p = P.
  - Minimum legal values are H ≥ 1 and P ≥ 2.
- Divider timing:
  - Launch at the terminating `rise` in cycle t.
  - Busy during cycles t+1..t+10.
  - `valid` is high during cycle t+11, and the outputs are visible from t+11.
- Overrun window: a `rise` that completes a measurement in cycles t+1..t+10 is discarded. This means any period ≤ 10 can drop measurements. Counting restarts normally after a discard.
- `overrun` is high in the cycle after the discarding `rise`.
- Timeout: `cnt` == MAX in HIGH or LOW causes `valid` and `stuck` to assert in the next cycle.
- Reset mid-operation: deasserting `rst_n` asynchronously clears everything. The first `rise` after release only arms the block.

## Test plan
- Input with period 100 and high 25, repeated 5 periods → first `valid` 11 cycles after the second detected rise; `duty` = 256, `period` = 100, `high_time` = 25; `overrun` is never set.
- Period 100, high 99 → `duty` = 1013. Period 1000, high 1 (CNT_W = 16) → `duty` = 1.
- CNT_W = 8, input held low after one rise/fall → 255 cycles after the last `rise`, `stuck` = 1, `duty` = 0, `period` = 255, `high_time` = 0, one `valid` pulse. A later 40/10 waveform → the first rise only arms; the next measurement gives `duty` = 256 and `stuck` = 0.
- CNT_W = 8, input held high → `stuck` = 1, `duty` = 1023, `period` = 255, `high_time` = 255.
- Period 4, high 2, continuous → results gated by the overrun window; every accepted result has `duty` = 512; `overrun` pulses on each rise inside the window; no corrupted `duty` value.
- Assert `rst_n` low during a divide (cycle t+5) → all outputs 0 immediately and no `valid`. After release, the 100/25 waveform resumes correct results after the arming edge.
